// File: rtl/penc_scan_iter.sv
// Sequential priority scanner: takes a multi-hot request vector and emits one set-bit index per beat.
// Optional build macro PENC_MSB_FIRST_EN adds a per-vector msb_first port for descending order.
//
// state | meaning
// IDLE  | no vector held, in_ready follows enable
// SCAN  | emitting beats for the accepted vector
module penc_scan_iter #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef PENC_MSB_FIRST_EN
    input  logic             msb_first,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               out_none_q, out_none_d;

    logic               take_last;
    logic               accept;
    logic               dir_msb;
    logic [WIDTH-1:0]   src_vec;
    logic [WIDTH-1:0]   src_rem;
    logic [IDX_W-1:0]   src_idx;

    function automatic logic [IDX_W-1:0] low_idx(input logic [WIDTH-1:0] v);
        low_idx = '0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (v[i]) low_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [IDX_W-1:0] high_idx(input logic [WIDTH-1:0] v);
        high_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) high_idx = IDX_W'(i);
        end
    endfunction

    assign take_last = out_valid_q && out_ready && out_last_q;
    assign in_ready  = enable && (state_q == IDLE || take_last);
    assign accept    = in_valid && in_ready;

`ifdef PENC_MSB_FIRST_EN
    // Direction is latched on accept so it cannot change mid-vector.
    logic msb_q, msb_d;
    assign dir_msb = accept ? msb_first : msb_q;
    always_comb begin
        msb_d = msb_q;
        if (accept) msb_d = msb_first;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) msb_q <= 1'b0;
        else        msb_q <= msb_d;
    end
`else
    assign dir_msb = 1'b0;
`endif

    // The next beat comes from the new vector on accept, otherwise from what is still pending.
    assign src_vec = accept ? in_data : pend_q;
    assign src_idx = dir_msb ? high_idx(src_vec) : low_idx(src_vec);
    assign src_rem = src_vec & ~(WIDTH'(1) << src_idx);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_none_d  = out_none_q;
        if (accept) begin
            state_d     = SCAN;
            out_valid_d = 1'b1;
            pend_d      = src_rem;
            out_idx_d   = src_idx;
            out_last_d  = (src_rem == '0);
            out_none_d  = (in_data == '0);
        end else if (out_valid_q && out_ready && !out_last_q) begin
            pend_d      = src_rem;
            out_idx_d   = src_idx;
            out_last_d  = (src_rem == '0);
        end else if (take_last) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_none_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_none_q  <= out_none_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_none  = out_none_q;
    assign busy      = (state_q == SCAN);

endmodule

// File: tb/tb_penc_scan_iter.sv
// Self-checking bench for penc_scan_iter: directed scenarios plus a randomized run
// compared against a queue-based model of the expected beat stream.
module tb_penc_scan_iter;
`ifdef PENC_MSB_FIRST_EN
    localparam int W = 16;
`else
    localparam int W = 8;
`endif
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          msb_first = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_none;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] idx;
        bit            last;
        bit            none;
    } beat_t;
    beat_t exp_q[$];

    penc_scan_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef PENC_MSB_FIRST_EN
        .msb_first(msb_first),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_none(out_none), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beat list: every set bit in the requested order, or a single "none" beat.
    task automatic model_push(input logic [W-1:0] v, input bit desc);
        int idxs[$];
        beat_t b;
        for (int i = 0; i < W; i++) if (v[i]) idxs.push_back(i);
        if (desc) idxs.reverse();
        if (idxs.size() == 0) begin
            b.idx = '0; b.last = 1'b1; b.none = 1'b1;
            exp_q.push_back(b);
        end else begin
            foreach (idxs[k]) begin
                b.idx  = IW'(idxs[k]);
                b.last = (k == idxs.size() - 1);
                b.none = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0 || out_last !== 1'b0 || out_none !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b idx=%0d last=%b none=%b, want all zero",
                     out_valid, busy, out_idx, out_last, out_none);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_scan();
        int exp_idx[4] = '{0, 2, 5, 7};
        in_valid = 1'b1; in_data = W'(8'hA5); out_ready = 1'b1; msb_first = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== IW'(exp_idx[k]) || out_last !== (k == 3) || out_none !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b busy=%b idx=%0d last=%b none=%b, want 1 1 %0d %b 0",
                         k, out_valid, busy, out_idx, out_last, out_none, exp_idx[k], (k == 3));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_zero_vector();
        in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_none !== 1'b1 || out_last !== 1'b1 || out_idx !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_beat: valid=%b none=%b last=%b idx=%0d busy=%b want 1 1 1 0 1",
                     out_valid, out_none, out_last, out_idx, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_none !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: valid=%b busy=%b none=%b want 0 0 0", out_valid, busy, out_none);
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = W'(8'h81); out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(0) || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b idx=%0d last=%b want 1 0 0", k, out_valid, out_idx, out_last);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== IW'(7) || out_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_second: valid=%b idx=%0d last=%b want 1 7 1", out_valid, out_idx, out_last);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = W'(8'h10); out_ready = 1'b1;
        step();
        in_data = W'(8'h03);
        #1;
        checks++;
        if (out_idx !== IW'(4) || out_last !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: idx=%0d last=%b in_ready=%b want 4 1 1", out_idx, out_last, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== IW'(0) || out_last !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: valid=%b idx=%0d last=%b busy=%b want 1 0 0 1", out_valid, out_idx, out_last, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== IW'(1) || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third: valid=%b idx=%0d last=%b want 1 1 1", out_valid, out_idx, out_last);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        in_valid = 1'b1; in_data = W'(8'hFF); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== IW'(0)) begin
            errors++;
            $display("FAIL rstmid_first: valid=%b idx=%0d want 1 0", out_valid, out_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b busy=%b last=%b want 0 0 0", out_valid, busy, out_last);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale%0d: valid=%b busy=%b want 0 0", k, out_valid, busy);
            end
        end
    endtask

`ifdef PENC_MSB_FIRST_EN
    task automatic test_msb_first();
        int exp_idx[3] = '{15, 4, 0};
        in_valid = 1'b1; in_data = 16'h8011; msb_first = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; msb_first = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(exp_idx[k]) || out_last !== (k == 2)) begin
                errors++;
                $display("FAIL msb_beat%0d: valid=%b idx=%0d last=%b want 1 %0d %b",
                         k, out_valid, out_idx, out_last, exp_idx[k], (k == 2));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_idle: valid=%b want 0", out_valid);
        end
    endtask
`endif

    task automatic test_random();
        bit exp_rdy;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef PENC_MSB_FIRST_EN
            msb_first = $urandom_range(0, 1);
`endif
            #1;
            exp_rdy = enable && (exp_q.size() == 0 || (out_ready && exp_q[0].last));
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== (exp_q.size() != 0) || busy !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid cyc%0d: valid=%b busy=%b want %b", cyc, out_valid, busy, (exp_q.size() != 0));
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (out_idx !== exp_q[0].idx || out_last !== exp_q[0].last || out_none !== exp_q[0].none) begin
                    errors++;
                    $display("FAIL rand_beat cyc%0d: idx=%0d last=%b none=%b want %0d %b %b",
                             cyc, out_idx, out_last, out_none, exp_q[0].idx, exp_q[0].last, exp_q[0].none);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && exp_rdy) model_push(in_data, msb_first);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2 * W + 4 && exp_q.size() != 0; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_q[0].idx || out_last !== exp_q[0].last || out_none !== exp_q[0].none) begin
                errors++;
                $display("FAIL rand_drain: valid=%b idx=%0d last=%b none=%b want 1 %0d %b %b",
                         out_valid, out_idx, out_last, out_none, exp_q[0].idx, exp_q[0].last, exp_q[0].none);
            end
            void'(exp_q.pop_front());
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_end: valid=%b left=%0d want 0 0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_zero_vector();
        test_stall();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef PENC_MSB_FIRST_EN
        test_msb_first();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/penc_scan_iter.md
Name: penc_scan_iter

Overview:
- Parametrised, sequential successor to the team's 8-bit one-hot encoder.
- Accepts a WIDTH-bit request vector with any number of bits set, then emits the index of every set bit, one index per handshake beat, lowest index first.
- Sits between request-collection logic (interrupt/status vectors) and consumers that service one index at a time.
- Resolves multi-hot inputs deterministically, which the one-hot encoder does not.

Parameters:
- WIDTH, 8, width of the request vector; legal range 2..64.
- IDX_W, $clog2(WIDTH), width of the emitted index; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  gates acceptance of new vectors only
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  WIDTH  request vector
- out_valid  output  1  out_idx/out_last/out_none are valid
- out_ready  input  1  consumer takes the current beat
- out_idx  output  IDX_W  index of the current set bit
- out_last  output  1  current beat is the final beat for this vector
- out_none  output  1  accepted vector was all-zero (single beat)
- busy  output  1  a vector is being scanned (state SCAN)

Behaviour:
- Registers: state (IDLE/SCAN), pend[WIDTH-1:0], and the registered outputs out_valid, out_idx, out_last, out_none.
- Reset (rst_n=0, asynchronous): state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0.
- in_ready (combinational) = enable && (state==IDLE || (out_valid && out_ready && out_last)).
  - A new vector is accepted in the same cycle the final beat is taken, giving back-to-back throughput.
- Accept = in_valid && in_ready. On the next edge:
  - state=SCAN, out_valid=1.
  - If in_data!=0: pend = in_data with its lowest set bit cleared; out_idx = lowest set index; out_last = (pend==0); out_none=0.
  - If in_data==0: out_idx=0, out_none=1, out_last=1.
- Latency: first beat valid one cycle after acceptance.
- SCAN with out_valid && !out_ready: all outputs and pend hold, with no change for any number of cycles.
- SCAN with out_valid && out_ready && !out_last: next edge loads out_idx = lowest set index of pend, clears that bit in pend, and sets out_last = (pend after clear == 0). One beat per cycle under continuous out_ready.
- SCAN with out_valid && out_ready && out_last:
  - With no simultaneous accept: next edge sets state=IDLE, out_valid=0, out_last=0, out_none=0. out_idx holds its value.
  - With a simultaneous accept: the new vector's first beat loads directly and state stays SCAN.
- Beats per vector = popcount(in_data), or exactly 1 if in_data==0.
- Index ordering is strictly ascending. Bit WIDTH-1 yields out_idx = WIDTH-1. No wrap-around.
- enable=0 mid-scan: the scan continues to completion; only new acceptance is blocked.
- in_data changes while in_ready=0: ignored.
- busy = (state==SCAN).
- Reset asserted mid-scan: all state is cleared asynchronously, remaining pending bits are discarded, and no further beats are emitted.

Optional Feature:
- Macro: PENC_MSB_FIRST_EN.
- Defined:
  - Adds input port msb_first (1 bit), sampled only on the accept cycle and held for the whole vector.
  - msb_first=1 emits indices in strictly descending order (highest set bit first); out_last marks the lowest set bit.
  - msb_first=0 behaves identically to the undefined build.
- Undefined: the port does not exist and ordering is always ascending.

Test Plan:
- Reset then in_data=8'b1010_0101, in_valid=1, out_ready=1 -> beats out_idx 0,2,5,7 on 4 consecutive cycles; out_last only with 7; busy drops the cycle after.
- in_data=8'b0000_0000 accepted -> one beat with out_none=1, out_last=1, out_idx=0; then IDLE.
- in_data=8'h81 with out_ready held low 5 cycles after the first beat -> out_idx=0 stable for 5 cycles; then 7 with out_last=1.
- Back-to-back: vector 8'h10, then 8'h03 presented with in_valid held -> beats 4(last), 0, 1(last) on consecutive cycles, no bubble.
- rst_n pulled low asynchronously after the first beat of 8'hFF -> out_valid=0 immediately; after release, in_ready=1 and no stale beats.
- PENC_MSB_FIRST_EN defined, WIDTH=16, msb_first=1, in_data=16'h8011 -> beats 15, 4, 0(last).
